// File: rtl/output_pipeline.sv
// output_pipeline: final histogram-equalizer stage. Streams 128-bit image words
// from m3, maps each byte through the m2 lookup table (pass-through when the
// entry tag is invalid), repacks the bytes and writes one word per 16 pixels to m4.
// Latency: first m4WE 19 cycles after start is sampled in IDLE, then one every
// 16 cycles. Throughput is one pixel per cycle with no bubbles between words.
// Ports:
//   clock, rst_n       clock, asynchronous active-low reset
//   start              level enable for the whole run; low aborts / re-arms
//   inputBaseOffset    address bit 15 for m3 reads and m4 writes
//   m3ReadAddr/Bus     image word fetch (1-cycle synchronous read)
//   m2ReadAddr/Bus     mapping lookup (1-cycle synchronous read)
//   m4WriteAddr/Bus/WE registered output word write, one-cycle WE pulse
//   done               registered, high after the final word is written
module output_pipeline #(
  parameter logic [14:0] ADDRESS_OF_LAST = 15'd19199,
  parameter logic [15:0] VALID_TAG       = 16'hAAAA
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic         inputBaseOffset,
  input  logic [127:0] m3ReadBus,
  input  logic [127:0] m2ReadBus,
  output logic [15:0]  m3ReadAddr,
  output logic [15:0]  m2ReadAddr,
  output logic [15:0]  m4WriteAddr,
  output logic [127:0] m4WriteBus,
  output logic         m4WE,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN,
    FINISHED
  } state_t;

  state_t         state;
  logic [14:0]    fetch_counter;
  logic [14:0]    cur_word_idx;
  logic [3:0]     pixel_idx;
  logic [127:0]   cur_word;
  logic [127:0]   out_word;

  // Stage S1 registers: the pixel whose lookup is arriving on m2ReadBus.
  logic           s1_valid;
  logic [7:0]     s1_pixel;
  logic [3:0]     s1_idx;
  logic [14:0]    s1_word_idx;

  logic [7:0]     cur_pixel;
  logic [7:0]     mapped;

  // Only the tag and the mapped value of an m2 entry are meaningful; byte 15
  // of out_word is never read because the top byte goes straight to m4WriteBus.
  logic           unused_bits;
  assign unused_bits = ^{m2ReadBus[127:36], m2ReadBus[19:8], out_word[127:120]};

  assign cur_pixel  = cur_word[{pixel_idx, 3'b000} +: 8];
  assign m2ReadAddr = {8'h00, cur_pixel};
  assign m3ReadAddr = {inputBaseOffset, fetch_counter};
  assign mapped     = (m2ReadBus[35:20] == VALID_TAG) ? m2ReadBus[7:0] : s1_pixel;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fetch_counter <= '0;
      cur_word_idx  <= '0;
      pixel_idx     <= '0;
      cur_word      <= '0;
      out_word      <= '0;
      s1_valid      <= 1'b0;
      s1_pixel      <= '0;
      s1_idx        <= '0;
      s1_word_idx   <= '0;
      m4WE          <= 1'b0;
      m4WriteAddr   <= '0;
      m4WriteBus    <= '0;
      done          <= 1'b0;
    end else begin
      m4WE     <= 1'b0;
      s1_valid <= 1'b0;

      // S1 is gated by start so an abort never completes a partial word.
      if (start && s1_valid) begin
        out_word[{s1_idx, 3'b000} +: 8] <= mapped;
        if (s1_idx == 4'd15) begin
          m4WriteBus  <= {mapped, out_word[119:0]};
          m4WriteAddr <= {inputBaseOffset, s1_word_idx};
          m4WE        <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          fetch_counter <= '0;
          cur_word_idx  <= '0;
          pixel_idx     <= '0;
          done          <= 1'b0;
          if (start) state <= PRIME;
        end

        PRIME: begin
          if (!start) begin
            state         <= IDLE;
            fetch_counter <= '0;
            cur_word_idx  <= '0;
            pixel_idx     <= '0;
          end else begin
            // Word 0 was addressed while in IDLE and is now on m3ReadBus.
            cur_word      <= m3ReadBus;
            cur_word_idx  <= '0;
            fetch_counter <= (ADDRESS_OF_LAST == 15'd0) ? 15'd0 : 15'd1;
            pixel_idx     <= '0;
            state         <= RUN;
          end
        end

        RUN: begin
          if (!start) begin
            state         <= IDLE;
            fetch_counter <= '0;
            cur_word_idx  <= '0;
            pixel_idx     <= '0;
          end else begin
            s1_valid    <= 1'b1;
            s1_pixel    <= cur_pixel;
            s1_idx      <= pixel_idx;
            s1_word_idx <= cur_word_idx;
            pixel_idx   <= pixel_idx + 4'd1;
            if (pixel_idx == 4'd15) begin
              if (cur_word_idx != ADDRESS_OF_LAST) begin
                // The next word's address has been stable for the whole word.
                cur_word     <= m3ReadBus;
                cur_word_idx <= fetch_counter;
                if (fetch_counter != ADDRESS_OF_LAST)
                  fetch_counter <= fetch_counter + 15'd1;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end

        DRAIN: begin
          if (!start) begin
            state         <= IDLE;
            fetch_counter <= '0;
            cur_word_idx  <= '0;
            pixel_idx     <= '0;
          end else if (m4WE) begin
            // The last word's write pulse is visible now.
            state <= FINISHED;
            done  <= 1'b1;
          end
        end

        FINISHED: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_pipeline.sv
module tb_output_pipeline;

  localparam logic [14:0] LAST = 15'd3;
  localparam int NW = 4;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         inputBaseOffset = 1'b0;
  logic [127:0] m3ReadBus;
  logic [127:0] m2ReadBus;
  logic [15:0]  m3ReadAddr;
  logic [15:0]  m2ReadAddr;
  logic [15:0]  m4WriteAddr;
  logic [127:0] m4WriteBus;
  logic         m4WE;
  logic         done;

  logic [127:0] img [0:7];
  logic [127:0] lut [0:255];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int           wr_cyc  [$];
  logic [15:0]  wr_addr [$];
  logic [127:0] wr_bus  [$];
  logic [15:0]  ra_log  [$];

  output_pipeline #(.ADDRESS_OF_LAST(LAST), .VALID_TAG(16'hAAAA)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .start(start),
    .inputBaseOffset(inputBaseOffset),
    .m3ReadBus(m3ReadBus),
    .m2ReadBus(m2ReadBus),
    .m3ReadAddr(m3ReadAddr),
    .m2ReadAddr(m2ReadAddr),
    .m4WriteAddr(m4WriteAddr),
    .m4WriteBus(m4WriteBus),
    .m4WE(m4WE),
    .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read memories, one cycle of latency.
  always @(posedge clock) begin
    m3ReadBus <= img[m3ReadAddr[2:0]];
    m2ReadBus <= lut[m2ReadAddr[7:0]];
  end

  // Observation log, sampled away from the active edge.
  always @(negedge clock) begin
    if (rst_n) begin
      ra_log.push_back(m3ReadAddr);
      if (m4WE) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(m4WriteAddr);
        wr_bus.push_back(m4WriteBus);
      end
    end
  end

  // Reference model: each output byte is the table value when the entry is
  // tagged valid, otherwise the original pixel.
  function automatic logic [7:0] map_px(input logic [7:0] v);
    logic [127:0] e;
    e = lut[v];
    if (e[35:20] == 16'hAAAA) return e[7:0];
    return v;
  endfunction

  function automatic logic [127:0] exp_word(input int w);
    logic [127:0] src;
    logic [127:0] r;
    src = img[w];
    for (int i = 0; i < 16; i++) r[8*i +: 8] = map_px(src[8*i +: 8]);
    return r;
  endfunction

  task automatic fill_random(input int bad_pct);
    logic [127:0] e;
    for (int w = 0; w < 8; w++) img[w] = {$urandom, $urandom, $urandom, $urandom};
    for (int v = 0; v < 256; v++) begin
      e = {$urandom, $urandom, $urandom, $urandom};
      e[35:20] = ($urandom_range(0, 99) < bad_pct) ? 16'(($urandom & 32'h7FFF) | 32'h1) : 16'hAAAA;
      lut[v] = e;
    end
  endtask

  // Starts a run and waits (bounded) for done. t is the cycle in which start
  // is sampled in IDLE; wb/ab are log positions at the start of the run.
  task automatic do_run(output int t, output int tdone, output int wb, output int ab);
    @(negedge clock);
    wb = wr_cyc.size();
    ab = ra_log.size();
    start = 1'b1;
    t = cyc;
    tdone = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        tdone = cyc;
        break;
      end
    end
    if (tdone < 0) begin
      total++; bad++;
      $display("FAIL run_timeout: done never rose, got %b want 1", done);
    end
  endtask

  task automatic stop_run();
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    total++;
    if (m4WE !== 1'b0 || done !== 1'b0 || m4WriteAddr !== 16'h0 || m4WriteBus !== 128'h0 || m3ReadAddr !== 16'h0) begin
      bad++;
      $display("FAIL reset_in: we=%b done=%b addr=%h bus=%h ra=%h want all zero", m4WE, done, m4WriteAddr, m4WriteBus, m3ReadAddr);
    end
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (m4WE !== 1'b0 || done !== 1'b0 || m3ReadAddr !== 16'h0) begin
      bad++;
      $display("FAIL reset_idle: we=%b done=%b ra=%h want 0 0 0000", m4WE, done, m3ReadAddr);
    end
  endtask

  task automatic test_stream(input int iter);
    int t, td, wb, ab, mx;
    logic mono;
    fill_random(20 + 10 * iter);
    do_run(t, td, wb, ab);
    total++;
    if (wr_cyc.size() - wb != NW) begin
      bad++;
      $display("FAIL stream%0d_count: got %0d writes want %0d", iter, wr_cyc.size() - wb, NW);
    end
    for (int w = 0; w < NW && wb + w < wr_cyc.size(); w++) begin
      total++;
      if (wr_cyc[wb + w] != t + 19 + 16 * w) begin
        bad++;
        $display("FAIL stream%0d_time w%0d: got cycle %0d want %0d", iter, w, wr_cyc[wb + w] - t, 19 + 16 * w);
      end
      total++;
      if (wr_addr[wb + w] !== 16'(w)) begin
        bad++;
        $display("FAIL stream%0d_addr w%0d: got %h want %h", iter, w, wr_addr[wb + w], 16'(w));
      end
      total++;
      if (wr_bus[wb + w] !== exp_word(w)) begin
        bad++;
        $display("FAIL stream%0d_data w%0d: got %h want %h", iter, w, wr_bus[wb + w], exp_word(w));
      end
    end
    total++;
    if (td != t + 20 + 16 * int'(LAST)) begin
      bad++;
      $display("FAIL stream%0d_done_time: got %0d want %0d", iter, td - t, 20 + 16 * int'(LAST));
    end
    mx = 0;
    mono = 1'b1;
    for (int j = ab; j < ra_log.size(); j++) begin
      if (int'(ra_log[j]) > mx) mx = int'(ra_log[j]);
      if (j > ab && ra_log[j] < ra_log[j - 1]) mono = 1'b0;
    end
    total++;
    if (mx != int'(LAST) || !mono) begin
      bad++;
      $display("FAIL stream%0d_fetch: max addr %0d monotonic %b want %0d 1", iter, mx, mono, LAST);
    end
    stop_run();
  endtask

  task automatic test_passthrough();
    int t, td, wb, ab;
    logic [127:0] want;
    logic [127:0] e;
    logic [7:0] b;
    fill_random(0);
    for (int i = 0; i < 16; i++) img[0][8*i +: 8] = 8'(i);
    for (int v = 0; v < 256; v++) begin
      e = 128'h0;
      e[35:20] = 16'hAAAA;
      e[7:0] = 8'hFF - 8'(v);
      lut[v] = e;
    end
    lut[5][35:20] = 16'h1234;
    for (int i = 0; i < 16; i++) want[8*i +: 8] = (i == 5) ? 8'h05 : 8'hFF - 8'(i);
    do_run(t, td, wb, ab);
    total++;
    if (wr_cyc.size() <= wb || wr_bus[wb] !== want) begin
      bad++;
      $display("FAIL passthrough_word0: got %h want %h", (wr_cyc.size() > wb) ? wr_bus[wb] : 128'hx, want);
    end else begin
      b = wr_bus[wb][47:40];
      total++;
      if (b !== 8'h05) begin
        bad++;
        $display("FAIL passthrough_byte5: got %h want 05", b);
      end
    end
    stop_run();
  endtask

  task automatic test_offset();
    int t, td, wb, ab;
    fill_random(10);
    inputBaseOffset = 1'b1;
    @(negedge clock);
    total++;
    if (m3ReadAddr !== 16'h8000) begin
      bad++;
      $display("FAIL offset_ra: got %h want 8000", m3ReadAddr);
    end
    do_run(t, td, wb, ab);
    total++;
    if (wr_cyc.size() - wb != NW || wr_addr[wb] !== 16'h8000 || wr_addr[wb + NW - 1] !== 16'h8003) begin
      bad++;
      $display("FAIL offset_wa: n=%0d first=%h last=%h want 4 8000 8003", wr_cyc.size() - wb,
               (wr_cyc.size() > wb) ? wr_addr[wb] : 16'hx, (wr_cyc.size() > wb) ? wr_addr[wr_addr.size() - 1] : 16'hx);
    end
    stop_run();
    inputBaseOffset = 1'b0;
  endtask

  task automatic test_abort();
    int t, td, wb, ab, n0;
    int drop_at [2] = '{10, 18};
    fill_random(15);
    for (int a = 0; a < 2; a++) begin
      @(negedge clock);
      n0 = wr_cyc.size();
      start = 1'b1;
      t = cyc;
      repeat (drop_at[a]) @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      total++;
      if (m3ReadAddr !== 16'h0 || m4WE !== 1'b0) begin
        bad++;
        $display("FAIL abort%0d_idle: ra=%h we=%b at T+%0d want 0000 0", a, m3ReadAddr, m4WE, cyc - t);
      end
      repeat (30) @(negedge clock);
      total++;
      if (wr_cyc.size() != n0 || done !== 1'b0) begin
        bad++;
        $display("FAIL abort%0d_nowrite: writes=%0d done=%b want 0 0", a, wr_cyc.size() - n0, done);
      end
    end
    do_run(t, td, wb, ab);
    total++;
    if (wr_cyc.size() - wb != NW || wr_cyc[wb] != t + 19 || wr_bus[wb] !== exp_word(0)) begin
      bad++;
      $display("FAIL abort_restart: n=%0d first at T+%0d want %0d at T+19", wr_cyc.size() - wb,
               (wr_cyc.size() > wb) ? wr_cyc[wb] - t : -1, NW);
    end
    stop_run();
  endtask

  task automatic test_done_hold();
    int t, td, wb, ab;
    fill_random(5);
    do_run(t, td, wb, ab);
    repeat (5) @(negedge clock);
    total++;
    if (done !== 1'b1 || wr_cyc.size() - wb != NW) begin
      bad++;
      $display("FAIL done_hold: done=%b writes=%0d want 1 %0d", done, wr_cyc.size() - wb, NW);
    end
    start = 1'b0;
    @(negedge clock);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_clear: got %b want 0", done);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int t, td, wb, ab;
    fill_random(25);
    @(negedge clock);
    start = 1'b1;
    repeat (25) @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (m4WE !== 1'b0 || done !== 1'b0 || m4WriteAddr !== 16'h0 || m4WriteBus !== 128'h0 || m3ReadAddr !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: we=%b done=%b addr=%h bus=%h ra=%h want all zero", m4WE, done, m4WriteAddr, m4WriteBus, m3ReadAddr);
    end
    start = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    do_run(t, td, wb, ab);
    total++;
    if (td != t + 20 + 16 * int'(LAST) || wr_cyc.size() - wb != NW || wr_bus[wb + NW - 1] !== exp_word(NW - 1)) begin
      bad++;
      $display("FAIL reset_rerun: done at T+%0d writes=%0d want T+%0d %0d", td - t, wr_cyc.size() - wb,
               20 + 16 * int'(LAST), NW);
    end
    stop_run();
  endtask

  initial begin
    for (int w = 0; w < 8; w++) img[w] = '0;
    for (int v = 0; v < 256; v++) lut[v] = '0;
    repeat (3) @(negedge clock);
    test_reset();
    for (int i = 0; i < 3; i++) test_stream(i);
    test_passthrough();
    test_offset();
    test_abort();
    test_done_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
